// File: rtl/x9_pkg.sv
// rtl/x9_pkg.sv - shared types and defaults for the X9 program sequencer
package x9_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int             X9_IW      = 9;
    localparam logic [X9_IW-1:0] X9_HALT_OP = 9'h1FF;

endpackage

// File: rtl/x9_run_seq_if.sv
// rtl/x9_run_seq_if.sv - sequencer run handshake, ROM fetch, branch and jump-table bundle (cyc_cnt with X9_CYCLE_CNT_EN)
interface x9_run_seq_if #(
    parameter int D  = 12,
    parameter int IW = 9,
    parameter int LW = 4
);
    logic          req;
    logic          done;
    logic          busy;
    logic [D-1:0]  prog_ctr;
    logic [IW-1:0] mach_code;
    logic          stall;
    logic          rel_en;
    logic          abs_en;
    logic          zeroQ;
    logic [LW-1:0] lut_idx;
    logic          lut_we;
    logic [LW-1:0] lut_waddr;
    logic [D-1:0]  lut_wdata;

`ifdef X9_CYCLE_CNT_EN
    logic [31:0]   cyc_cnt;

    modport slave (
        input  req, mach_code, stall, rel_en, abs_en, zeroQ,
        input  lut_idx, lut_we, lut_waddr, lut_wdata,
        output done, busy, prog_ctr, cyc_cnt
    );

    modport master (
        output req, mach_code, stall, rel_en, abs_en, zeroQ,
        output lut_idx, lut_we, lut_waddr, lut_wdata,
        input  done, busy, prog_ctr, cyc_cnt
    );
`else
    modport slave (
        input  req, mach_code, stall, rel_en, abs_en, zeroQ,
        input  lut_idx, lut_we, lut_waddr, lut_wdata,
        output done, busy, prog_ctr
    );

    modport master (
        output req, mach_code, stall, rel_en, abs_en, zeroQ,
        output lut_idx, lut_we, lut_waddr, lut_wdata,
        input  done, busy, prog_ctr
    );
`endif

endinterface

// File: rtl/x9_jump_lut.sv
// rtl/x9_jump_lut.sv - jump-target table, synchronous write, asynchronous read
module x9_jump_lut #(
    parameter int D  = 12,
    parameter int LW = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic [LW-1:0] waddr_i,
    input  logic [D-1:0]  wdata_i,
    input  logic [LW-1:0] raddr_i,
    output logic [D-1:0]  rdata_o
);
    localparam int DEPTH = 2 ** LW;

    logic [D-1:0] tab_q [DEPTH];

    // Table storage: cleared on reset, one write per cycle; a same-index read sees the old entry
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_q[i] <= '0;
            end
        end else if (we_i) begin
            tab_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = tab_q[raddr_i];

endmodule

// File: rtl/x9_run_seq.sv
// rtl/x9_run_seq.sv - X9 program sequencer: PC, run handshake, halt detection; X9_CYCLE_CNT_EN adds the run-cycle counter
module x9_run_seq
    import x9_pkg::*;
#(
    parameter int            D          = 12,
    parameter int            IW         = X9_IW,
    parameter int            LW         = 4,
    parameter logic [D-1:0]  START_ADDR = '0,
    parameter logic [IW-1:0] HALT_OP    = IW'(X9_HALT_OP)
) (
    input  logic        clk,
    input  logic        reset,
    x9_run_seq_if.slave bus
);
    seq_state_t   state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         busy_q, done_q;
    logic [D-1:0] lut_rdata;

    x9_jump_lut #(
        .D  (D),
        .LW (LW)
    ) u_lut (
        .clk_i   (clk),
        .reset_i (reset),
        .we_i    (bus.lut_we),
        .waddr_i (bus.lut_waddr),
        .wdata_i (bus.lut_wdata),
        .raddr_i (bus.lut_idx),
        .rdata_o (lut_rdata)
    );

    // Next state and next PC; within RUN the checks are in priority order stall, halt, abs, rel, sequential
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                pc_d = START_ADDR;
                if (bus.req) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (bus.mach_code == HALT_OP) begin
                        state_d = DONE;
                    end else if (bus.abs_en) begin
                        pc_d = lut_rdata;
                    end else if (bus.rel_en && bus.zeroQ) begin
                        pc_d = pc_q + lut_rdata;
                    end else if (pc_q == {D{1'b1}}) begin
                        state_d = DONE;
                    end else begin
                        pc_d = pc_q + D'(1);
                    end
                end
            end
            DONE: begin
                if (!bus.req) begin
                    state_d = IDLE;
                    pc_d    = START_ADDR;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_ADDR;
            end
        endcase
    end

    // State, PC and the registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.prog_ctr = pc_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef X9_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Run-cycle counter: clears at run start, counts every RUN cycle including stalls, saturates
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && bus.req) begin
            cyc_d = '0;
        end else if (state_q == RUN && cyc_q != 32'hFFFF_FFFF) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign bus.cyc_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_x9_run_seq.sv
// tb/tb_x9_run_seq.sv - self-checking bench for x9_run_seq (cycle-counter checks with X9_CYCLE_CNT_EN)
module tb_x9_run_seq;
    localparam int            D     = 12;
    localparam int            IW    = 9;
    localparam int            LW    = 4;
    localparam int            PSIZE = 1 << D;
    localparam logic [IW-1:0] HALT  = 9'h1FF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    x9_run_seq_if #(.D(D), .IW(IW), .LW(LW)) ifc ();
    x9_run_seq_if #(.D(4), .IW(IW), .LW(LW)) ifc4 ();

    logic [IW-1:0] rom [PSIZE];
    assign ifc.mach_code  = rom[ifc.prog_ctr];
    assign ifc4.mach_code = '0;

    x9_run_seq #(
        .D(D), .IW(IW), .LW(LW), .START_ADDR(12'h000), .HALT_OP(HALT)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    x9_run_seq #(
        .D(4), .IW(IW), .LW(LW), .START_ADDR(4'h0), .HALT_OP(HALT)
    ) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc4.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a run is either active, finished, or neither; pc follows the branch rules
    int          m_pc = 0;
    bit          m_run = 0;
    bit          m_fin = 0;
    longint      m_cyc = 0;
    int unsigned m_tab [16];
    bit          chk_en = 0;

    always @(posedge clk) begin
        int unsigned t;
        if (reset) begin
            m_run  = 0;
            m_fin  = 0;
            m_pc   = 0;
            m_cyc  = 0;
            chk_en = 1;
            foreach (m_tab[i]) m_tab[i] = 0;
        end else begin
            t = m_tab[ifc.lut_idx];
            if (!m_run && !m_fin) begin
                m_pc = 0;
                if (ifc.req) begin
                    m_run = 1;
                    m_cyc = 0;
                end
            end else if (m_run) begin
                if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
                if (!ifc.stall) begin
                    if (rom[m_pc] == HALT) begin
                        m_run = 0;
                        m_fin = 1;
                    end else if (ifc.abs_en) begin
                        m_pc = int'(t);
                    end else if (ifc.rel_en && ifc.zeroQ) begin
                        m_pc = int'((m_pc + t) % PSIZE);
                    end else if (m_pc == PSIZE - 1) begin
                        m_run = 0;
                        m_fin = 1;
                    end else begin
                        m_pc = m_pc + 1;
                    end
                end
            end else if (!ifc.req) begin
                m_fin = 0;
                m_pc  = 0;
            end
            if (ifc.lut_we) m_tab[ifc.lut_waddr] = ifc.lut_wdata;
        end
    end

    // Every-cycle comparison of the main DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc", 32'(ifc.prog_ctr), 32'(m_pc));
            chk("model_busy", 32'(ifc.busy), 32'(m_run));
            chk("model_done", 32'(ifc.done), 32'(m_fin));
`ifdef X9_CYCLE_CNT_EN
            chk("model_cyc", ifc.cyc_cnt, 32'(m_cyc));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int pc, input bit busy, input bit done);
        chk({name, "_pc"}, 32'(ifc.prog_ctr), 32'(pc));
        chk({name, "_busy"}, 32'(ifc.busy), 32'(busy));
        chk({name, "_done"}, 32'(ifc.done), 32'(done));
    endtask

    task automatic expect_out4(input string name, input int pc, input bit busy, input bit done);
        chk({name, "_pc"}, 32'(ifc4.prog_ctr), 32'(pc));
        chk({name, "_busy"}, 32'(ifc4.busy), 32'(busy));
        chk({name, "_done"}, 32'(ifc4.done), 32'(done));
    endtask

    task automatic wait_pc(input string name, input int tgt, input int budget);
        int n = 0;
        while (int'(ifc.prog_ctr) != tgt && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(ifc.prog_ctr), 32'(tgt));
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = '0;
    endtask

    task automatic lut_write(input int idx, input int val);
        ifc.lut_we    = 1'b1;
        ifc.lut_waddr = 4'(idx);
        ifc.lut_wdata = 12'(val);
        tick();
        ifc.lut_we    = 1'b0;
    endtask

    task automatic branch_idle();
        ifc.abs_en = 1'b0;
        ifc.rel_en = 1'b0;
        ifc.zeroQ  = 1'b0;
        ifc.stall  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_len;
        clear_rom();
        ifc.req = 1'b0;  ifc.stall = 1'b0; ifc.rel_en = 1'b0; ifc.abs_en = 1'b0;
        ifc.zeroQ = 1'b0; ifc.lut_idx = '0; ifc.lut_we = 1'b0; ifc.lut_waddr = '0; ifc.lut_wdata = '0;
        ifc4.req = 1'b0; ifc4.stall = 1'b0; ifc4.rel_en = 1'b0; ifc4.abs_en = 1'b0;
        ifc4.zeroQ = 1'b0; ifc4.lut_idx = '0; ifc4.lut_we = 1'b0; ifc4.lut_waddr = '0; ifc4.lut_wdata = '0;

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        expect_out("reset", 0, 0, 0);

        // Linear program halting at address 5
        rom[5] = HALT;
        ifc.req = 1'b1;
        tick();
        expect_out("t1_start", 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            expect_out("t1_seq", i, 1, 0);
        end
        tick();
        expect_out("t1_done", 5, 0, 1);
        tick();
        expect_out("t1_hold", 5, 0, 1);
        ifc.req = 1'b0;
        tick();
        expect_out("t1_idle", 0, 0, 0);

        // Absolute jump, and absolute winning over a simultaneous relative branch
        clear_rom();
        rom[12'h045] = HALT;
        lut_write(3, 12'h040);
        ifc.req = 1'b1;
        tick(); tick(); tick();
        expect_out("t2_pc2", 2, 1, 0);
        ifc.abs_en = 1'b1; ifc.lut_idx = 4'd3;
        tick();
        expect_out("t2_abs", 12'h040, 1, 0);
        ifc.abs_en = 1'b0;
        tick();
        expect_out("t2_seq", 12'h041, 1, 0);
        ifc.abs_en = 1'b1; ifc.rel_en = 1'b1; ifc.zeroQ = 1'b1;
        tick();
        expect_out("t2_abs_rel", 12'h040, 1, 0);
        branch_idle();
        wait_pc("t2_wait", 12'h045, 10);
        tick();
        expect_out("t2_done", 12'h045, 0, 1);
        ifc.req = 1'b0;
        tick();

        // Relative branch of -2, taken with zeroQ and not taken without
        clear_rom();
        rom[12'h012] = HALT;
        lut_write(1, 12'hFFE);
        ifc.req = 1'b1;
        wait_pc("t3_wait", 12'h010, 40);
        ifc.rel_en = 1'b1; ifc.zeroQ = 1'b1; ifc.lut_idx = 4'd1;
        tick();
        expect_out("t3_rel_taken", 12'h00E, 1, 0);
        branch_idle();
        wait_pc("t3_wait2", 12'h010, 5);
        ifc.rel_en = 1'b1; ifc.zeroQ = 1'b0;
        tick();
        expect_out("t3_rel_not", 12'h011, 1, 0);
        branch_idle();
        tick(); tick();
        expect_out("t3_done", 12'h012, 0, 1);
        ifc.req = 1'b0;
        tick();

        // Small program space: runs to the last address and stops without wrapping
        ifc4.req = 1'b1;
        tick();
        expect_out4("t4_start", 0, 1, 0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            expect_out4("t4_seq", i, 1, 0);
        end
        tick();
        expect_out4("t4_end", 15, 0, 1);
        tick();
        expect_out4("t4_hold", 15, 0, 1);
        ifc4.req = 1'b0;
        tick();
        expect_out4("t4_idle", 0, 0, 0);

        // Stall holds the PC and masks a pending halt
        clear_rom();
        rom[3] = HALT;
        ifc.req = 1'b1;
        wait_pc("t5_wait", 3, 10);
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("t5_stall", 3, 1, 0);
        end
        ifc.stall = 1'b0;
        tick();
        expect_out("t5_done", 3, 0, 1);
`ifdef X9_CYCLE_CNT_EN
        chk("t5_cyc", ifc.cyc_cnt, 32'd7);
`endif
        ifc.req = 1'b0;
        tick();

        // Reset mid-run clears the table; same-index write and read sees the old entry
        clear_rom();
        rom[9]       = HALT;
        rom[12'h031] = HALT;
        ifc.req = 1'b1;
        wait_pc("t6_wait", 7, 12);
        reset = 1'b1;
        tick();
        expect_out("t6_reset", 0, 0, 0);
        reset = 1'b0;
        tick();
        expect_out("t6_restart", 0, 1, 0);
        ifc.abs_en = 1'b1; ifc.lut_idx = 4'd3;
        tick();
        expect_out("t6_tab_zero", 0, 1, 0);
        ifc.abs_en = 1'b0;
        tick();
        expect_out("t6_seq", 1, 1, 0);
        ifc.abs_en = 1'b1; ifc.lut_idx = 4'd2;
        ifc.lut_we = 1'b1; ifc.lut_waddr = 4'd2; ifc.lut_wdata = 12'h030;
        tick();
        expect_out("t6_old_val", 0, 1, 0);
        ifc.lut_we = 1'b0;
        tick();
        expect_out("t6_new_val", 12'h030, 1, 0);
        ifc.abs_en = 1'b0;
        wait_pc("t6_wait2", 12'h031, 5);
        tick();
        expect_out("t6_done", 12'h031, 0, 1);
        ifc.req = 1'b0;
        tick();

        // Randomised traffic against the model
        foreach (rom[i]) rom[i] = ($urandom_range(0, 99) < 3) ? HALT : IW'($urandom);
        run_len = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_run) run_len++;
            else run_len = 0;
            reset = (run_len > 300) || ($urandom_range(0, 199) == 0);
            if (m_run)      ifc.req = 1'($urandom_range(0, 1));
            else if (m_fin) ifc.req = ($urandom_range(0, 9) < 6);
            else            ifc.req = ($urandom_range(0, 9) < 7);
            ifc.stall     = ($urandom_range(0, 4) == 0);
            ifc.abs_en    = ($urandom_range(0, 9) == 0);
            ifc.rel_en    = ($urandom_range(0, 6) == 0);
            ifc.zeroQ     = 1'($urandom_range(0, 1));
            ifc.lut_idx   = 4'($urandom);
            ifc.lut_we    = ($urandom_range(0, 4) == 0);
            ifc.lut_waddr = 4'($urandom);
            ifc.lut_wdata = 12'($urandom);
            tick();
        end
        reset = 1'b0;
        ifc.req = 1'b0;
        ifc.lut_we = 1'b0;
        branch_idle();
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
